// File: rtl/reg_file_pkg.sv
// reg_file_pkg: opcode constants, size defaults and the write-intent decode
// shared by the register file and its hazard pipeline.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [6:0] OP_LOAD_IMM = 7'b1111111;
    localparam logic [6:0] OP_NOP      = 7'b0000000;
    localparam logic [6:0] OP_ALU      = 7'b0110011;

    function automatic logic is_wr_intent(input logic [6:0] op);
        return (op == OP_LOAD_IMM) || (op == OP_ALU);
    endfunction

endpackage

// File: rtl/rf_hazard_pipe.sv
// rf_hazard_pipe: destination/intent shift pipeline and source-hazard compare.
// With RF_BYPASS_EN the last stage is forwarded and so never raises a hazard.
module rf_hazard_pipe
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WB_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [ADDR_W-1:0] rd_wb,
    output logic              hazard
);

`ifdef RF_BYPASS_EN
    localparam int CMP_N = WB_DELAY - 1;
`else
    localparam int CMP_N = WB_DELAY;
`endif

    logic [ADDR_W-1:0]   rd_p [WB_DELAY];
    logic [WB_DELAY-1:0] vld_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WB_DELAY; i++) begin
                rd_p[i] <= '0;
            end
            vld_p <= '0;
        end else begin
            rd_p[0]  <= rd_addr;
            vld_p[0] <= is_wr_intent(opcode);
            for (int i = 1; i < WB_DELAY; i++) begin
                rd_p[i]  <= rd_p[i-1];
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign rd_wb = rd_p[WB_DELAY-1];

    // x0 never holds a pending value, so a zero destination never matches
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < CMP_N; i++) begin
            if (vld_p[i] && (rd_p[i] != '0) &&
                ((rd_p[i] == rs1_addr) || (rd_p[i] == rs2_addr))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// reg_file: register file with delayed write-back, x0 hardwired to zero,
// saturating write counter. Define RF_BYPASS_EN for same-cycle forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WB_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        OPCODE,
    input  logic [ADDR_W-1:0] RD_ADDR,
    input  logic [ADDR_W-1:0] RS1_ADDR,
    input  logic [ADDR_W-1:0] RS2_ADDR,
    input  logic              wr_en_RF,
    input  logic [DATA_W-1:0] Data_In_RF,
    output logic [DATA_W-1:0] RS1_DATA,
    output logic [DATA_W-1:0] RS2_DATA,
    output logic              HAZARD,
    output logic [15:0]       WR_CNT
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] rd_wb;
    logic              wr_commit;

    rf_hazard_pipe #(
        .ADDR_W   (ADDR_W),
        .WB_DELAY (WB_DELAY)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .opcode   (OPCODE),
        .rd_addr  (RD_ADDR),
        .rs1_addr (RS1_ADDR),
        .rs2_addr (RS2_ADDR),
        .rd_wb    (rd_wb),
        .hazard   (HAZARD)
    );

    // write-back is authoritative: the intent bit does not gate the write
    assign wr_commit = wr_en_RF && (rd_wb != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            WR_CNT <= '0;
        end else if (wr_commit) begin
            regs[rd_wb] <= Data_In_RF;
            if (WR_CNT != 16'hFFFF) begin
                WR_CNT <= WR_CNT + 16'd1;
            end
        end
    end

    always_comb begin
        RS1_DATA = (RS1_ADDR == '0) ? '0 : regs[RS1_ADDR];
        RS2_DATA = (RS2_ADDR == '0) ? '0 : regs[RS2_ADDR];
`ifdef RF_BYPASS_EN
        if (wr_commit && (rd_wb == RS1_ADDR)) begin
            RS1_DATA = Data_In_RF;
        end
        if (wr_commit && (rd_wb == RS2_ADDR)) begin
            RS2_DATA = Data_In_RF;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file (default parameters).
// Committed writes are queued at drive time and read back after the edge.
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  OPCODE;
    logic [4:0]  RD_ADDR, RS1_ADDR, RS2_ADDR;
    logic        wr_en_RF;
    logic [31:0] Data_In_RF;
    logic [31:0] RS1_DATA, RS2_DATA;
    logic        HAZARD;
    logic [15:0] WR_CNT;

    reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .OPCODE     (OPCODE),
        .RD_ADDR    (RD_ADDR),
        .RS1_ADDR   (RS1_ADDR),
        .RS2_ADDR   (RS2_ADDR),
        .wr_en_RF   (wr_en_RF),
        .Data_In_RF (Data_In_RF),
        .RS1_DATA   (RS1_DATA),
        .RS2_DATA   (RS2_DATA),
        .HAZARD     (HAZARD),
        .WR_CNT     (WR_CNT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] mregs [32];
    logic [4:0]  mp [2];
    logic        mi [2];
    logic [15:0] mcnt;
    int          n_chk = 0;
    int          n_err = 0;
    int          hz_cycles;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        for (int i = 0; i < 2; i++) begin
            mp[i] = '0;
            mi[i] = 1'b0;
        end
        mcnt = '0;
        sb.delete();
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a,
                                         input logic we,
                                         input logic [31:0] wd);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (we && mp[1] == a) return wd;
`endif
        return mregs[a];
    endfunction

    function automatic logic m_hz(input logic [4:0] a1, input logic [4:0] a2);
        logic h = 1'b0;
        for (int i = 0; i < 2; i++) begin
`ifdef RF_BYPASS_EN
            if (i == 1) continue;
`endif
            if (mi[i] && mp[i] != 0 && (mp[i] == a1 || mp[i] == a2))
                h = 1'b1;
        end
        return h;
    endfunction

    task automatic tick();
        sb_t e;
        @(posedge clk);
        if (!rst) begin
            if (wr_en_RF && mp[1] != 0) begin
                mregs[mp[1]] = Data_In_RF;
                if (mcnt != 16'hFFFF) mcnt++;
            end
            mp[1] = mp[0];
            mi[1] = mi[0];
            mp[0] = RD_ADDR;
            mi[0] = (OPCODE == 7'b1111111) || (OPCODE == 7'b0110011);
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            RS2_ADDR = e.a;
            #1;
            chk("sb_readback", RS2_DATA, e.d);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic we, input logic [31:0] wd,
                         input bit ck);
        OPCODE = op;
        RD_ADDR = rd;
        RS1_ADDR = rs1;
        RS2_ADDR = rs2;
        wr_en_RF = we;
        Data_In_RF = wd;
        if (ck && we && mp[1] != 0) sb.push_back('{mp[1], wd});
        #1;
        if (ck) begin
            chk("hazard", HAZARD, m_hz(rs1, rs2));
            chk("rs1_data", RS1_DATA, m_rd(rs1, we, wd));
            chk("rs2_data", RS2_DATA, m_rd(rs2, we, wd));
            chk("wr_cnt", WR_CNT, mcnt);
        end
        if (HAZARD) hz_cycles++;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        OPCODE = OP_NOP;
        wr_en_RF = 1'b0;
        m_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        OPCODE = OP_NOP;
        RD_ADDR = '0;
        RS1_ADDR = 5'd3;
        RS2_ADDR = 5'd4;
        wr_en_RF = 1'b0;
        Data_In_RF = '0;
        m_clear();
        #12;
        chk("rst_rs1", RS1_DATA, 32'h0);
        chk("rst_rs2", RS2_DATA, 32'h0);
        chk("rst_cnt", WR_CNT, 32'h0);
        chk("rst_hz", HAZARD, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // load-immediate to x3, data two cycles later
        drive(OP_LOAD_IMM, 5'd3, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 0, 0, 1, 32'h000ABCDE, 1);
        RS1_ADDR = 5'd3;
        #1;
        chk("limm_x3", RS1_DATA, 32'h000ABCDE);
        chk("limm_cnt", WR_CNT, 32'd1);

        // ALU write to x0 is discarded
        drive(OP_ALU, 0, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 0, 0, 1, 32'hFFFFFFFF, 1);
        RS1_ADDR = 5'd0;
        #1;
        chk("x0_data", RS1_DATA, 32'h0);
        chk("x0_cnt", WR_CNT, 32'd1);

        // RAW hazard on x7
        hz_cycles = 0;
        drive(OP_ALU, 5'd7, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 5'd7, 0, 0, 0, 1);
        drive(OP_NOP, 0, 5'd7, 0, 1, 32'hCAFE0007, 1);
        drive(OP_NOP, 0, 5'd7, 0, 0, 0, 1);
`ifdef RF_BYPASS_EN
        chk("hz_cycles", hz_cycles, 32'd1);
`else
        chk("hz_cycles", hz_cycles, 32'd2);
`endif
        RS1_ADDR = 5'd7;
        #1;
        chk("x7_data", RS1_DATA, 32'hCAFE0007);

        // NOP carries no intent
        drive(OP_NOP, 5'd9, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 0, 5'd9, 0, 0, 1);
        chk("nop_x9", RS2_DATA, 32'h0);

        // write-back without intent still writes
        drive(OP_NOP, 5'd12, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 5'd12, 0, 1, 32'h0BADF00D, 1);

        // back-to-back random traffic
        for (int i = 0; i < 24; i++) begin
            drive(($urandom_range(0, 1) != 0) ? OP_ALU : OP_LOAD_IMM,
                  5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  1'(i >= 2), $urandom(), 1);
        end
        drive(OP_NOP, 0, 0, 0, 1, $urandom(), 1);
        drive(OP_NOP, 0, 0, 0, 1, $urandom(), 1);

        // asynchronous reset mid-cycle with x5 written and in flight
        do_reset();
        drive(OP_ALU, 5'd5, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 0, 0, 0, 0, 1);
        drive(OP_NOP, 0, 0, 0, 1, 32'h00001234, 1);
        OPCODE = OP_ALU;
        RD_ADDR = 5'd5;
        wr_en_RF = 1'b0;
        tick();
        RS1_ADDR = 5'd5;
        #1;
        chk("pre_rst_x5", RS1_DATA, 32'h00001234);
        chk("pre_rst_hz", HAZARD, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_x5", RS1_DATA, 32'h0);
        chk("arst_cnt", WR_CNT, 32'h0);
        chk("arst_hz", HAZARD, 32'h0);
        m_clear();
        OPCODE = OP_NOP;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(OP_NOP, 0, 5'd5, 5'd5, 0, 0, 1);

        // counter saturation
        do_reset();
        for (int k = 0; k < 70000 && mcnt != 16'hFFFE; k++) begin
            drive(OP_ALU, 5'd1, 0, 0, 1, k, 0);
        end
        chk("sat_pre", WR_CNT, 32'h0000FFFE);
        drive(OP_ALU, 5'd1, 5'd1, 0, 1, 32'h5A5A0001, 1);
        drive(OP_ALU, 5'd1, 5'd1, 0, 1, 32'h5A5A0002, 1);
        drive(OP_ALU, 5'd1, 5'd1, 0, 1, 32'h5A5A0003, 1);
        chk("sat_cnt", WR_CNT, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
